// File: rtl/branch_predictor_pkg.sv
// Shared types and constants for the fetch-stage branch predictor.
// BTB entries carry a fixed-width tag field; narrower tags are zero-extended.
package bp_pkg;

    typedef enum logic [1:0] {
        BP_MISS_TAKEN    = 2'd0,
        BP_MISS_NOTTAKEN = 2'd1,
        BP_CORRECT       = 2'd2,
        BP_NONE          = 2'd3
    } bp_status_e;

    localparam logic [1:0]  BP_WEAK_NT   = 2'b01;
    localparam int unsigned BP_TAG_W_MAX = 30;

    typedef struct packed {
        logic                    valid;
        logic [BP_TAG_W_MAX-1:0] tag;
        logic [31:0]             target;
        logic                    branch;
        logic                    jump;
    } btb_entry_t;

    function automatic logic bp_pred_taken(input logic [1:0] ctr);
        return ctr[1];
    endfunction

endpackage

// File: rtl/branch_predictor_sat_counter2.sv
// Next value of a 2-bit saturating counter: step toward 3 when inc, toward 0 otherwise.
module sat_counter2
    import bp_pkg::*;
(
    input  logic [1:0] cur,
    input  logic       inc,
    output logic [1:0] nxt
);

    always_comb begin
        nxt = cur;
        if (inc) begin
            if (cur != 2'b11) nxt = cur + 2'b01;
        end else begin
            if (cur != 2'b00) nxt = cur - 2'b01;
        end
    end

endmodule

// File: rtl/branch_predictor.sv
// Direct-mapped BTB plus PHT of 2-bit counters: combinational IF lookup,
// trained at the clock edge from the resolved EX instruction.
module branch_predictor
    import bp_pkg::*;
#(
    parameter int unsigned BTB_IDX_BITS = 6,
    parameter int unsigned PHT_IDX_BITS = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] IF_pc,
    output logic        IF_BTBhit,
    output logic        IF_Branch,
    output logic        IF_Jump,
    output logic [31:0] IF_pc_imm,
    output logic [1:0]  IF_branch_prediction,
    input  logic        EX_valid,
    input  logic [31:0] EX_pc,
    input  logic [31:0] EX_pc_imm,
    input  logic        EX_Branch,
    input  logic        EX_Jump,
    input  logic        EX_ALUSrc,
    input  logic        EX_taken,
    input  logic [1:0]  EX_branch_prediction,
    output logic [1:0]  prediction_status,
    output logic [31:0] branch_count,
    output logic [31:0] mispredict_count
);

    localparam int unsigned BTB_N = 1 << BTB_IDX_BITS;
    localparam int unsigned PHT_N = 1 << PHT_IDX_BITS;

    logic [BTB_IDX_BITS-1:0] if_bidx, ex_bidx;
    logic [PHT_IDX_BITS-1:0] if_pidx, ex_pidx;
    logic [BP_TAG_W_MAX-1:0] if_tag, ex_tag;

    logic [BTB_N-1:0] btb_valid;
    btb_entry_t       btb_data [BTB_N];
    logic [1:0]       pht      [PHT_N];

    btb_entry_t if_entry, wr_entry;
    bp_status_e status;
    logic       ex_br, btb_we, mispredict;
    logic [1:0] pht_cur, pht_nxt;
    logic       unused_bits;

    assign if_bidx = IF_pc[BTB_IDX_BITS+1:2];
    assign ex_bidx = EX_pc[BTB_IDX_BITS+1:2];
    assign if_pidx = IF_pc[PHT_IDX_BITS+1:2];
    assign ex_pidx = EX_pc[PHT_IDX_BITS+1:2];
    assign if_tag  = BP_TAG_W_MAX'(IF_pc[31:BTB_IDX_BITS+2]);
    assign ex_tag  = BP_TAG_W_MAX'(EX_pc[31:BTB_IDX_BITS+2]);

    assign unused_bits = ^{IF_pc[1:0], EX_pc[1:0], EX_branch_prediction[0]};

    // Data storage is not reset, so its valid copy is qualified by the reset-able bit.
    always_comb begin
        if_entry       = btb_data[if_bidx];
        if_entry.valid = if_entry.valid & btb_valid[if_bidx];
        IF_BTBhit      = if_entry.valid && (if_entry.tag == if_tag);
        IF_Branch      = IF_BTBhit & if_entry.branch;
        IF_Jump        = IF_BTBhit & if_entry.jump;
        IF_pc_imm      = IF_BTBhit ? if_entry.target : '0;
    end

    assign IF_branch_prediction = pht[if_pidx];

    assign ex_br  = EX_valid && EX_Branch;
    assign btb_we = EX_valid && (EX_Branch || (EX_Jump && !EX_ALUSrc));

    always_comb begin
        status = BP_NONE;
        if (ex_br) begin
            if (!bp_pred_taken(EX_branch_prediction) && EX_taken)
                status = BP_MISS_TAKEN;
            else if (bp_pred_taken(EX_branch_prediction) && !EX_taken)
                status = BP_MISS_NOTTAKEN;
            else
                status = BP_CORRECT;
        end
    end

    assign prediction_status = status;
    assign mispredict = (status == BP_MISS_TAKEN) || (status == BP_MISS_NOTTAKEN);

    always_comb begin
        wr_entry        = '0;
        wr_entry.valid  = 1'b1;
        wr_entry.tag    = ex_tag;
        wr_entry.target = EX_pc_imm;
        wr_entry.branch = EX_Branch;
        wr_entry.jump   = !EX_Branch;
    end

    always_ff @(posedge clk) begin
        if (btb_we) btb_data[ex_bidx] <= wr_entry;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)      btb_valid <= '0;
        else if (btb_we) btb_valid[ex_bidx] <= 1'b1;
    end

    // PHT training reads the live counter, not the value piped down from IF.
    assign pht_cur = pht[ex_pidx];

    sat_counter2 u_sat_counter2 (
        .cur (pht_cur),
        .inc (EX_taken),
        .nxt (pht_nxt)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)     pht <= '{default: BP_WEAK_NT};
        else if (ex_br) pht[ex_pidx] <= pht_nxt;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            branch_count     <= '0;
            mispredict_count <= '0;
        end else if (status != BP_NONE) begin
            if (branch_count != '1) branch_count <= branch_count + 32'd1;
            if (mispredict && (mispredict_count != '1))
                mispredict_count <= mispredict_count + 32'd1;
        end
    end

endmodule

// File: tb/tb_branch_predictor.sv
// Directed bench for branch_predictor: a PC-level reference model checked every
// cycle, plus literal expectations at the interesting points.
module tb_branch_predictor;

    logic        clk, rst_n;
    logic [31:0] if_pc;
    logic        if_hit, if_br, if_jmp;
    logic [31:0] if_imm;
    logic [1:0]  if_pred;
    logic        ex_valid, ex_branch, ex_jump, ex_alusrc, ex_taken;
    logic [31:0] ex_pc, ex_pc_imm;
    logic [1:0]  ex_pred;
    logic [1:0]  status;
    logic [31:0] bcount, mcount;

    int total = 0;
    int bad   = 0;

    branch_predictor #(.BTB_IDX_BITS(6), .PHT_IDX_BITS(8)) dut (
        .clk                  (clk),
        .rst_n                (rst_n),
        .IF_pc                (if_pc),
        .IF_BTBhit            (if_hit),
        .IF_Branch            (if_br),
        .IF_Jump              (if_jmp),
        .IF_pc_imm            (if_imm),
        .IF_branch_prediction (if_pred),
        .EX_valid             (ex_valid),
        .EX_pc                (ex_pc),
        .EX_pc_imm            (ex_pc_imm),
        .EX_Branch            (ex_branch),
        .EX_Jump              (ex_jump),
        .EX_ALUSrc            (ex_alusrc),
        .EX_taken             (ex_taken),
        .EX_branch_prediction (ex_pred),
        .prediction_status    (status),
        .branch_count         (bcount),
        .mispredict_count     (mcount)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: an entry hits when the PC that trained it has the same word address.
    bit          m_valid [64];
    logic [31:0] m_owner [64];
    logic [31:0] m_tgt   [64];
    bit          m_isbr  [64];
    int          m_ctr   [256];
    longint      m_bc, m_mc;
    localparam longint CMAX = 64'hFFFF_FFFF;

    function automatic int exp_status();
        if (!(ex_valid && ex_branch)) return 3;
        if (ex_pred >= 2 && !ex_taken) return 1;
        if (ex_pred < 2 && ex_taken) return 0;
        return 2;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        int st, b, p;
        if (!rst_n) begin
            for (int i = 0; i < 64; i++) m_valid[i] = 1'b0;
            for (int i = 0; i < 256; i++) m_ctr[i] = 1;
            m_bc = 0;
            m_mc = 0;
        end else begin
            st = exp_status();
            p  = int'((ex_pc >> 2) % 256);
            b  = int'((ex_pc >> 2) % 64);
            if (ex_valid && ex_branch)
                m_ctr[p] = ex_taken ? ((m_ctr[p] == 3) ? 3 : m_ctr[p] + 1)
                                    : ((m_ctr[p] == 0) ? 0 : m_ctr[p] - 1);
            if (ex_valid && (ex_branch || (ex_jump && !ex_alusrc))) begin
                m_valid[b] = 1'b1;
                m_owner[b] = ex_pc;
                m_tgt[b]   = ex_pc_imm;
                m_isbr[b]  = ex_branch;
            end
            if (st != 3) begin
                if (m_bc < CMAX) m_bc++;
                if (st < 2 && m_mc < CMAX) m_mc++;
            end
        end
    end

    always @(negedge clk) begin
        int  b, p;
        bit  hit;
        b   = int'((if_pc >> 2) % 64);
        p   = int'((if_pc >> 2) % 256);
        hit = m_valid[b] && (m_owner[b][31:2] == if_pc[31:2]);
        check("m_hit",    32'(if_hit),  32'(hit));
        check("m_branch", 32'(if_br),   32'(hit && m_isbr[b]));
        check("m_jump",   32'(if_jmp),  32'(hit && !m_isbr[b]));
        check("m_target", if_imm,       hit ? m_tgt[b] : 32'h0);
        check("m_pred",   32'(if_pred), 32'(m_ctr[p]));
        check("m_status", 32'(status),  32'(exp_status()));
        check("m_bcount", bcount,       32'(m_bc));
        check("m_mcount", mcount,       32'(m_mc));
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        ex_valid  = 1'b0;
        ex_pc     = '0;
        ex_pc_imm = '0;
        ex_branch = 1'b0;
        ex_jump   = 1'b0;
        ex_alusrc = 1'b0;
        ex_taken  = 1'b0;
        ex_pred   = 2'b00;
    endtask

    task automatic drive_ex(input logic [31:0] pc, input logic [31:0] imm, input logic br,
                            input logic jmp, input logic alusrc, input logic tk,
                            input logic [1:0] pr);
        ex_valid  = 1'b1;
        ex_pc     = pc;
        ex_pc_imm = imm;
        ex_branch = br;
        ex_jump   = jmp;
        ex_alusrc = alusrc;
        ex_taken  = tk;
        ex_pred   = pr;
    endtask

    initial begin
        rst_n = 1'b0;
        if_pc = 32'h100;
        idle();
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        #1;
        check("rst_hit",    32'(if_hit),  32'd0);
        check("rst_pred",   32'(if_pred), 32'd1);
        check("rst_status", 32'(status),  32'd3);
        check("rst_bcount", bcount,       32'd0);

        // First taken branch at 0x100, predicted weakly not-taken.
        drive_ex(32'h100, 32'h80, 1'b1, 1'b0, 1'b0, 1'b1, 2'b01);
        #1;
        check("first_status",  32'(status), 32'd0);
        check("first_pre_hit", 32'(if_hit), 32'd0);
        tick(); idle(); #1;
        check("first_hit",    32'(if_hit),  32'd1);
        check("first_branch", 32'(if_br),   32'd1);
        check("first_target", if_imm,       32'h80);
        check("first_pred",   32'(if_pred), 32'd2);
        check("first_bcount", bcount,       32'd1);
        check("first_mcount", mcount,       32'd1);

        for (int k = 0; k < 4; k++) begin
            drive_ex(32'h100, 32'h80, 1'b1, 1'b0, 1'b0, 1'b1, (k == 0) ? 2'b10 : 2'b11);
            #1 check("sat_status", 32'(status), 32'd2);
            tick();
        end
        idle(); #1;
        check("sat_pred",   32'(if_pred), 32'd3);
        check("sat_bcount", bcount,       32'd5);

        drive_ex(32'h100, 32'h80, 1'b1, 1'b0, 1'b0, 1'b0, 2'b11);
        #1 check("nt_status", 32'(status), 32'd1);
        tick(); idle(); #1;
        check("nt_pred",   32'(if_pred), 32'd2);
        check("nt_mcount", mcount,       32'd2);

        // JAL at 0x200 shares BTB index 0 with 0x100.
        drive_ex(32'h200, 32'h400, 1'b0, 1'b1, 1'b0, 1'b0, 2'b00);
        #1 check("jal_status", 32'(status), 32'd3);
        tick(); idle();
        if_pc = 32'h200; #1;
        check("jal_hit",    32'(if_hit), 32'd1);
        check("jal_jump",   32'(if_jmp), 32'd1);
        check("jal_branch", 32'(if_br),  32'd0);
        check("jal_target", if_imm,      32'h400);
        if_pc = 32'h100; #1;
        check("alias_hit",    32'(if_hit),  32'd0);
        check("alias_target", if_imm,       32'h0);
        check("alias_pred",   32'(if_pred), 32'd2);

        drive_ex(32'h300, 32'h500, 1'b0, 1'b1, 1'b1, 1'b0, 2'b00);
        tick(); idle();
        if_pc = 32'h300; #1;
        check("jalr_hit",    32'(if_hit),  32'd0);
        check("jalr_pred",   32'(if_pred), 32'd1);
        check("jalr_bcount", bcount,       32'd6);

        // Same-cycle read and write of index 0: lookup sees the old contents.
        if_pc = 32'h100;
        drive_ex(32'h100, 32'h90, 1'b1, 1'b0, 1'b0, 1'b0, 2'b10);
        #1;
        check("same_hit",    32'(if_hit),  32'd0);
        check("same_pred",   32'(if_pred), 32'd2);
        check("same_status", 32'(status),  32'd1);
        tick(); idle(); #1;
        check("after_hit",    32'(if_hit),  32'd1);
        check("after_target", if_imm,       32'h90);
        check("after_pred",   32'(if_pred), 32'd1);
        check("after_mcount", mcount,       32'd3);

        rst_n = 1'b0; #1;
        check("pulse_bcount", bcount,      32'd0);
        check("pulse_hit",    32'(if_hit), 32'd0);
        tick(); rst_n = 1'b1;

        // Ten branches, mispredicted at k = 0, 3, 6.
        for (int k = 0; k < 10; k++) begin
            drive_ex(32'h1000 + 32'(4 * k), 32'h2000, 1'b1, 1'b0, 1'b0,
                     (k == 0 || k == 3 || k == 6), 2'b01);
            tick();
        end
        idle(); #1;
        check("ten_bcount", bcount, 32'd10);
        check("ten_mcount", mcount, 32'd3);
        if_pc = 32'h1000; #1;
        check("ten_hit",  32'(if_hit),  32'd1);
        check("ten_pred", 32'(if_pred), 32'd2);

        drive_ex(32'h1004, 32'h3000, 1'b1, 1'b0, 1'b0, 1'b1, 2'b01);
        tick();
        rst_n = 1'b0; #1;
        check("mid_bcount", bcount,       32'd0);
        check("mid_mcount", mcount,       32'd0);
        check("mid_hit",    32'(if_hit),  32'd0);
        check("mid_pred",   32'(if_pred), 32'd1);
        tick();
        if_pc = 32'h1004; #1;
        check("held_hit",    32'(if_hit),  32'd0);
        check("held_pred",   32'(if_pred), 32'd1);
        check("held_bcount", bcount,       32'd0);
        idle();
        rst_n = 1'b1;
        tick(); #1;
        check("rel_hit",    32'(if_hit), 32'd0);
        check("rel_bcount", bcount,      32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
